// File: rtl/bcd_timekeeper.sv
// Prescaled hh:mm:ss timekeeper with BCD display digits, 12/24-hour display and validated time load.
// Optional alarm comparator is built when BCD_TIMEKEEPER_ALARM_EN is defined.
module bcd_timekeeper #(
    parameter int unsigned CLK_DIV       = 100000000,
    parameter int unsigned HOURS_PER_DAY = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mode_12h,
    input  logic       set_stb,
    input  logic [4:0] set_hh,
    input  logic [5:0] set_mm,
    input  logic [5:0] set_ss,
`ifdef BCD_TIMEKEEPER_ALARM_EN
    input  logic       alarm_arm,
    input  logic [4:0] alarm_hh,
    input  logic [5:0] alarm_mm,
    output logic       alarm,
`endif
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       set_err
);

    localparam logic [31:0] PRESC_MAX = 32'(CLK_DIV - 32'd1);
    localparam logic [4:0]  HH_MAX    = 5'(HOURS_PER_DAY - 32'd1);

    logic [31:0] r_presc;
    logic [4:0]  r_hh;
    logic [5:0]  r_mm;
    logic [5:0]  r_ss;
    logic        r_sec_tick;
    logic        r_day_wrap;
    logic        r_set_err;
    logic        r_alarm;

    logic        w_presc_wrap;
    logic        w_set_ok;
    logic        w_ss_last;
    logic        w_mm_last;
    logic        w_hh_last;
    logic        w_day_end;
    logic        w_alarm_hit;
    logic [5:0]  w_ss_nxt;
    logic [5:0]  w_mm_nxt;
    logic [4:0]  w_hh_nxt;
    logic [5:0]  w_hh_disp;
    logic        w_pm;
    logic [7:0]  w_hh_bcd;
    logic [7:0]  w_mm_bcd;
    logic [7:0]  w_ss_bcd;

    // Splits a value 0..59 into {tens, ones} using bounded comparisons only.
    function automatic logic [7:0] bcd2(input logic [5:0] v);
        logic [3:0] t;
        logic [3:0] o;
        if (v >= 6'd50) begin
            t = 4'd5;
            o = 4'(v - 6'd50);
        end else if (v >= 6'd40) begin
            t = 4'd4;
            o = 4'(v - 6'd40);
        end else if (v >= 6'd30) begin
            t = 4'd3;
            o = 4'(v - 6'd30);
        end else if (v >= 6'd20) begin
            t = 4'd2;
            o = 4'(v - 6'd20);
        end else if (v >= 6'd10) begin
            t = 4'd1;
            o = 4'(v - 6'd10);
        end else begin
            t = 4'd0;
            o = v[3:0];
        end
        return {t, o};
    endfunction

    // Next-second values with minute/hour carry and load validation.
    always_comb begin
        w_presc_wrap = (r_presc == PRESC_MAX);
        w_set_ok     = (set_hh <= HH_MAX) && (set_mm <= 6'd59) && (set_ss <= 6'd59);
        w_ss_last    = (r_ss == 6'd59);
        w_mm_last    = (r_mm == 6'd59);
        w_hh_last    = (r_hh == HH_MAX);
        w_day_end    = w_ss_last && w_mm_last && w_hh_last;

        if (w_ss_last) begin
            w_ss_nxt = 6'd0;
        end else begin
            w_ss_nxt = r_ss + 6'd1;
        end

        if (w_ss_last) begin
            if (w_mm_last) begin
                w_mm_nxt = 6'd0;
            end else begin
                w_mm_nxt = r_mm + 6'd1;
            end
        end else begin
            w_mm_nxt = r_mm;
        end

        if (w_ss_last && w_mm_last) begin
            if (w_hh_last) begin
                w_hh_nxt = 5'd0;
            end else begin
                w_hh_nxt = r_hh + 5'd1;
            end
        end else begin
            w_hh_nxt = r_hh;
        end
    end

`ifdef BCD_TIMEKEEPER_ALARM_EN
    // Alarm matches the time being entered, which must sit on a whole minute.
    always_comb begin
        w_alarm_hit = alarm_arm && (w_ss_nxt == 6'd0) && (w_mm_nxt == alarm_mm) && (w_hh_nxt == alarm_hh);
    end
    assign alarm = r_alarm;
`else
    assign w_alarm_hit = 1'b0;
`endif

    // Prescaler, time counters and one-cycle event pulses; a strobe always pre-empts counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc    <= 32'd0;
            r_hh       <= 5'd0;
            r_mm       <= 6'd0;
            r_ss       <= 6'd0;
            r_sec_tick <= 1'b0;
            r_day_wrap <= 1'b0;
            r_set_err  <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_day_wrap <= 1'b0;
            r_set_err  <= 1'b0;
            r_alarm    <= 1'b0;
            if (set_stb) begin
                if (w_set_ok) begin
                    r_hh    <= set_hh;
                    r_mm    <= set_mm;
                    r_ss    <= set_ss;
                    r_presc <= 32'd0;
                end else begin
                    r_set_err <= 1'b1;
                end
            end else if (run) begin
                if (w_presc_wrap) begin
                    r_presc    <= 32'd0;
                    r_hh       <= w_hh_nxt;
                    r_mm       <= w_mm_nxt;
                    r_ss       <= w_ss_nxt;
                    r_sec_tick <= 1'b1;
                    r_day_wrap <= w_day_end;
                    r_alarm    <= w_alarm_hit;
                end else begin
                    r_presc <= r_presc + 32'd1;
                end
            end else begin
                r_presc <= r_presc;
            end
        end
    end

    // Hour display mapping: 0 and 12 both show as 12 in 12-hour mode.
    always_comb begin
        if (mode_12h) begin
            if (r_hh == 5'd0) begin
                w_hh_disp = 6'd12;
            end else if (r_hh > 5'd12) begin
                w_hh_disp = {1'b0, r_hh} - 6'd12;
            end else begin
                w_hh_disp = {1'b0, r_hh};
            end
            w_pm = (r_hh >= 5'd12);
        end else begin
            w_hh_disp = {1'b0, r_hh};
            w_pm      = 1'b0;
        end
    end

    assign w_hh_bcd  = bcd2(w_hh_disp);
    assign w_mm_bcd  = bcd2(r_mm);
    assign w_ss_bcd  = bcd2(r_ss);

    assign hour_tens = w_hh_bcd[7:4];
    assign hour_ones = w_hh_bcd[3:0];
    assign min_tens  = w_mm_bcd[7:4];
    assign min_ones  = w_mm_bcd[3:0];
    assign sec_tens  = w_ss_bcd[7:4];
    assign sec_ones  = w_ss_bcd[3:0];
    assign pm        = w_pm;
    assign sec_tick  = r_sec_tick;
    assign day_wrap  = r_day_wrap;
    assign set_err   = r_set_err;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Self-checking bench for bcd_timekeeper: seconds-of-day reference model, directed cases, random traffic.
module tb_bcd_timekeeper;

    localparam int CLK_DIV = 4;
    localparam int HPD     = 24;
    localparam int DAY     = HPD * 3600;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       run      = 1'b0;
    logic       mode_12h = 1'b0;
    logic       set_stb  = 1'b0;
    logic [4:0] set_hh   = 5'd0;
    logic [5:0] set_mm   = 6'd0;
    logic [5:0] set_ss   = 6'd0;
    logic [3:0] hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic       pm, sec_tick, day_wrap, set_err;
`ifdef BCD_TIMEKEEPER_ALARM_EN
    logic       alarm_arm = 1'b0;
    logic [4:0] alarm_hh  = 5'd0;
    logic [5:0] alarm_mm  = 6'd0;
    logic       alarm;
`endif

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    int   m_presc = 0;
    int   m_secs  = 0;
    logic m_tick  = 1'b0;
    logic m_wrap  = 1'b0;
    logic m_err   = 1'b0;
    logic m_alarm = 1'b0;

    bcd_timekeeper #(.CLK_DIV(CLK_DIV), .HOURS_PER_DAY(HPD)) dut (
        .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h),
        .set_stb(set_stb), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
`ifdef BCD_TIMEKEEPER_ALARM_EN
        .alarm_arm(alarm_arm), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm(alarm),
`endif
        .hour_tens(hour_tens), .hour_ones(hour_ones), .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .pm(pm),
        .sec_tick(sec_tick), .day_wrap(day_wrap), .set_err(set_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time as seconds-of-day plus a cycle counter within the second.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_presc <= 0; m_secs <= 0;
            m_tick <= 1'b0; m_wrap <= 1'b0; m_err <= 1'b0; m_alarm <= 1'b0;
        end else begin
            m_tick <= 1'b0; m_wrap <= 1'b0; m_err <= 1'b0; m_alarm <= 1'b0;
            if (set_stb) begin
                if (int'(set_hh) < HPD && int'(set_mm) < 60 && int'(set_ss) < 60) begin
                    m_secs  <= int'(set_hh) * 3600 + int'(set_mm) * 60 + int'(set_ss);
                    m_presc <= 0;
                end else begin
                    m_err <= 1'b1;
                end
            end else if (run) begin
                if (m_presc == CLK_DIV - 1) begin
                    m_presc <= 0;
                    m_secs  <= (m_secs + 1) % DAY;
                    m_tick  <= 1'b1;
                    m_wrap  <= ((m_secs + 1) % DAY == 0);
`ifdef BCD_TIMEKEEPER_ALARM_EN
                    m_alarm <= alarm_arm && ((m_secs + 1) % DAY == int'(alarm_hh) * 3600 + int'(alarm_mm) * 60);
`endif
                end else begin
                    m_presc <= m_presc + 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin : cmp
        int h, mi, s, dh, epm;
        if (cmp_en) begin
            h  = m_secs / 3600;
            mi = (m_secs / 60) % 60;
            s  = m_secs % 60;
            if (mode_12h) begin
                dh  = (h % 12 == 0) ? 12 : h % 12;
                epm = (h >= 12) ? 1 : 0;
            end else begin
                dh  = h;
                epm = 0;
            end
            chk("hour_tens", hour_tens, dh / 10);
            chk("hour_ones", hour_ones, dh % 10);
            chk("min_tens",  min_tens,  mi / 10);
            chk("min_ones",  min_ones,  mi % 10);
            chk("sec_tens",  sec_tens,  s / 10);
            chk("sec_ones",  sec_ones,  s % 10);
            chk("pm",        pm,        epm);
            chk("sec_tick",  sec_tick,  m_tick);
            chk("day_wrap",  day_wrap,  m_wrap);
            chk("set_err",   set_err,   m_err);
`ifdef BCD_TIMEKEEPER_ALARM_EN
            chk("alarm",     alarm,     m_alarm);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic load(input int hh, input int mm, input int ss);
        set_hh  = 5'(hh);
        set_mm  = 6'(mm);
        set_ss  = 6'(ss);
        set_stb = 1'b1;
        cyc(1);
        set_stb = 1'b0;
    endtask

    initial begin : stim
        int hh_tab [4];
        int pm_tab [4];
        int ten_tab[4];
        int one_tab[4];
        int k, ticks, seen, cnt;

        hh_tab  = '{0, 11, 12, 13};
        ten_tab = '{1, 1, 1, 0};
        one_tab = '{2, 1, 2, 1};
        pm_tab  = '{0, 0, 1, 1};

        run = 1'b1;
        #1 reset = 1'b1;
        cmp_en = 1'b1;
        cyc(3);
        chk("rst_hour_tens", hour_tens, 0);
        chk("rst_sec_ones", sec_ones, 0);
        chk("rst_sec_tick", sec_tick, 0);

        // Divide-by-4 from reset: ticks on edges 4, 8, 12.
        reset = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            cyc(1);
            chk("div_tick", sec_tick, (n % 4 == 0) ? 1 : 0);
            chk("div_sec_ones", sec_ones, n / 4);
        end

        // End-of-day wrap.
        load(23, 59, 58);
        chk("load_hour_ones", hour_ones, 3);
        chk("load_no_tick", sec_tick, 0);
        ticks = 0;
        seen  = 0;
        for (k = 0; k < 20; k++) begin
            cyc(1);
            if (sec_tick) ticks++;
            if (day_wrap) begin
                seen = 1;
                break;
            end
        end
        chk("daywrap_seen", seen, 1);
        chk("ticks_to_wrap", ticks, 2);
        chk("wrap_tick", sec_tick, 1);
        chk("wrap_hour_tens", hour_tens, 0);
        chk("wrap_hour_ones", hour_ones, 0);
        chk("wrap_min_ones", min_ones, 0);
        chk("wrap_sec_ones", sec_ones, 0);

        // 12-hour display mapping.
        run = 1'b0;
        mode_12h = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load(hh_tab[i], 0, 0);
            chk("h12_tens", hour_tens, ten_tab[i]);
            chk("h12_ones", hour_ones, one_tab[i]);
            chk("h12_pm", pm, pm_tab[i]);
        end

        // Rejected loads leave 13:00:00 intact.
        load(24, 0, 0);
        chk("bad_hh_err", set_err, 1);
        chk("bad_hh_keep", hour_ones, 1);
        load(10, 60, 0);
        chk("bad_mm_err", set_err, 1);
        chk("bad_mm_keep", hour_ones, 1);
        chk("bad_mm_keep_min", min_tens, 0);
        cyc(1);
        chk("err_one_cycle", set_err, 0);

        // Load coincident with prescaler wrap.
        mode_12h = 1'b0;
        run = 1'b1;
        for (k = 0; k < 10; k++) begin
            if (m_presc == CLK_DIV - 1) break;
            cyc(1);
        end
        chk("wrap_phase_found", (k < 10) ? 1 : 0, 1);
        load(5, 6, 7);
        chk("coinc_no_tick", sec_tick, 0);
        chk("coinc_hour", hour_ones, 5);
        chk("coinc_min", min_ones, 6);
        chk("coinc_sec", sec_ones, 7);

        // Freeze mid-second, then resume where the prescaler left off.
        cyc(2);
        run = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (sec_tick) cnt++;
        end
        chk("frozen_no_tick", cnt, 0);
        chk("frozen_sec", sec_ones, 7);
        run = 1'b1;
        for (k = 1; k <= 10; k++) begin
            cyc(1);
            if (sec_tick) break;
        end
        chk("resume_edges", k, 2);
        chk("resume_sec", sec_ones, 8);

        // Asynchronous reset mid-cycle.
        load(12, 34, 56);
        cyc(1);
        reset = 1'b1;
        #1;
        chk("async_hour_ones", hour_ones, 0);
        chk("async_min_tens", min_tens, 0);
        chk("async_sec_ones", sec_ones, 0);
        chk("async_tick", sec_tick, 0);
        cyc(2);
        reset = 1'b0;
        cyc(3);

`ifdef BCD_TIMEKEEPER_ALARM_EN
        alarm_hh  = 5'd0;
        alarm_mm  = 6'd1;
        alarm_arm = 1'b1;
        load(0, 0, 58);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (alarm) cnt++;
        end
        chk("alarm_armed_count", cnt, 1);
        alarm_arm = 1'b0;
        load(0, 0, 58);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (alarm) cnt++;
        end
        chk("alarm_disarmed_count", cnt, 0);
`endif

        // Randomized traffic, biased toward end-of-hour/day loads.
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 31) == 0) mode_12h = ~mode_12h;
`ifdef BCD_TIMEKEEPER_ALARM_EN
            if ($urandom_range(0, 63) == 0) begin
                alarm_arm = 1'($urandom_range(0, 1));
                alarm_hh  = ($urandom_range(0, 1) == 1) ? 5'd0 : 5'($urandom_range(0, 23));
                alarm_mm  = 6'($urandom_range(0, 59));
            end
`endif
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 2) == 0) begin
                    set_hh = 5'(($urandom_range(0, 1) == 1) ? 23 : $urandom_range(0, 23));
                    set_mm = 6'd59;
                    set_ss = 6'($urandom_range(50, 59));
                end else begin
                    set_hh = 5'($urandom_range(0, 31));
                    set_mm = 6'($urandom_range(0, 63));
                    set_ss = 6'($urandom_range(0, 63));
                end
                set_stb = 1'b1;
                cyc(1);
                set_stb = 1'b0;
            end else begin
                cyc(1);
            end
        end

        cyc(2);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_timekeeper.md
BCD_TIMEKEEPER -- requirements
Module: bcd_timekeeper

Interface
REQ-001 Parameter CLK_DIV, default 100000000: clk cycles per second, legal 2..2^32-1.
REQ-002 Parameter HOURS_PER_DAY, default 24: legal 12 or 24. Sets the internal hour range 0..HOURS_PER_DAY-1.
REQ-003 clk  in  1  single clock; all logic is on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 run  in  1  1 = prescaler advances; 0 = time frozen, prescaler held.
REQ-006 mode_12h  in  1  display select: 1 = 12-hour display with pm flag; 0 = 24-hour display.
REQ-007 set_stb  in  1  single-cycle load strobe.
REQ-008 set_hh/set_mm/set_ss  in  5/6/6  binary time to load.
REQ-009 hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits.
REQ-010 pm  out  1  in 12-hour display, 1 when internal hour is 12 or greater; 0 otherwise.
REQ-011 sec_tick  out  1  one-cycle pulse on each seconds increment.
REQ-012 day_wrap  out  1  one-cycle pulse when time wraps from the last second of the day to 00:00:00.
REQ-013 set_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-014 The prescaler SHALL count 0..CLK_DIV-1 while run=1 and SHALL wrap to 0 at CLK_DIV-1.
REQ-015 On the edge where the prescaler wraps, seconds SHALL increment, and sec_tick SHALL be 1 for the following cycle exactly.
REQ-016 Seconds and minutes SHALL wrap 59->0 with carry; hours SHALL wrap HOURS_PER_DAY-1->0.
REQ-017 day_wrap SHALL assert in the same cycle as the sec_tick caused by the last-second-of-day to 00:00:00 transition.
REQ-018 With run=0, time and prescaler SHALL hold, and sec_tick/day_wrap SHALL stay 0.
REQ-019 set_stb with set_hh<HOURS_PER_DAY, set_mm<60 and set_ss<60 SHALL load the time on that edge and clear the prescaler to 0.
REQ-020 On a valid load, no sec_tick or day_wrap SHALL be produced for that edge.
REQ-021 set_stb with any field out of range SHALL leave time and prescaler unchanged, and set_err SHALL be 1 for the following cycle.
REQ-022 If set_stb coincides with a prescaler wrap, the load SHALL win and that tick SHALL be discarded.
REQ-023 A load SHALL be honoured regardless of run.
REQ-024 Outputs SHALL be decoded combinationally from the registered counters: zero added latency after the updating edge.
REQ-025 12-hour display: internal hour 0 SHALL show as 12 with pm=0; hour 12 SHALL show as 12 with pm=1; hour h in 13..23 SHALL show as h-12 with pm=1.
REQ-026 24-hour display: the hour digits SHALL show the internal hour, and pm SHALL be 0.
REQ-027 Toggling mode_12h SHALL affect the display only, never the count.
REQ-028 Digit arithmetic SHALL use no run-time divider; tens/ones derive from bounded comparisons or separate BCD counters.

Reset
REQ-029 While reset=1, time SHALL be 00:00:00 and the prescaler SHALL be 0.
REQ-030 While reset=1, sec_tick, day_wrap, set_err and alarm SHALL be 0; all digits SHALL be 0 (12-hour display shows 12, pm=0).
REQ-031 Reset asserted mid-count SHALL abort any pending tick or load immediately.
REQ-032 Counting SHALL resume from prescaler 0 on the first edge after reset deasserts.

Configuration
REQ-033 Macro BCD_TIMEKEEPER_ALARM_EN defined SHALL add inputs alarm_arm (1), alarm_hh (5) and alarm_mm (6), plus output alarm (1).
REQ-034 With the macro defined, alarm SHALL be a one-cycle pulse coincident with the sec_tick that enters hh:mm:00 equal to alarm_hh:alarm_mm while alarm_arm=1.
REQ-035 With the macro defined, a load SHALL never fire the alarm.
REQ-036 With the macro undefined, those ports and the alarm logic SHALL not exist.

Verification
REQ-037 CLK_DIV=4, run=1 from reset: sec_tick on cycles 4, 8, 12; sec_ones reads 1, 2, 3.
REQ-038 Load 23:59:58, run=1: after 2 ticks, day_wrap=1 with the tick and digits read 00:00:00.
REQ-039 HOURS_PER_DAY=24, mode_12h=1: internal 00, 11, 12 and 13 display 12/pm0, 11/pm0, 12/pm1 and 01/pm1.
REQ-040 Load 24:00:00 or 10:60:00: set_err pulses and time is unchanged; set_stb coincident with a prescaler wrap loads the new value and sec_tick stays 0.
REQ-041 run=0 for 10 cycles mid-second: no tick occurs and the prescaler value is preserved; reset pulsed mid-count zeroes all outputs asynchronously.
REQ-042 ALARM_EN, alarm 00:01 armed, start 00:00:58: alarm pulses once with the tick into 00:01:00; with alarm_arm=0 it does not pulse.
